// File: rtl/forwarding_scoreboard.sv
// Latency-aware register scoreboard and forward-select generator at ID->EX.
// Define FORWARD_SCOREBOARD_STATS_EN to add the saturating stall_cycles counter.
module forwarding_scoreboard #(
    parameter int REGFILE_LEN              = 6,
    parameter int NUM_SRC                  = 2,
    parameter int FORWARD_ALU_SELECT_WIDTH = 2,
    parameter int MAX_LAT                  = 4,
    parameter int LAT_WIDTH                = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     issue_valid,
    input  logic                                     issue_reg_write,
    input  logic [REGFILE_LEN-1:0]                   issue_rd,
    input  logic [LAT_WIDTH-1:0]                     issue_lat,
    input  logic                                     flush,
    input  logic [NUM_SRC-1:0]                       src_valid,
    input  logic [NUM_SRC*REGFILE_LEN-1:0]           src_rs,
    output logic                                     stall,
    output logic [NUM_SRC*FORWARD_ALU_SELECT_WIDTH-1:0] forward_sel,
    output logic [REGFILE_LEN:0]                     busy_count
`ifdef FORWARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                              stall_cycles
`endif
);

    localparam int NREG = 2 ** REGFILE_LEN;
    localparam int SW   = FORWARD_ALU_SELECT_WIDTH;
    localparam int BW   = REGFILE_LEN + 1;

    localparam logic [LAT_WIDTH-1:0] LAT_MAX = LAT_WIDTH'(MAX_LAT);
    localparam logic [LAT_WIDTH-1:0] C_ONE   = LAT_WIDTH'(1);
    localparam logic [LAT_WIDTH-1:0] C_TWO   = LAT_WIDTH'(2);
    localparam logic [LAT_WIDTH-1:0] C_THREE = LAT_WIDTH'(3);
    localparam logic [SW-1:0]        SEL_EXMEM = SW'(2);
    localparam logic [SW-1:0]        SEL_MEMWB = SW'(1);

    logic [LAT_WIDTH-1:0]        ctr_q [NREG];
    logic [LAT_WIDTH-1:0]        ctr_d [NREG];
    logic [NUM_SRC*SW-1:0]       fwd_sel_q;
    logic [NUM_SRC*SW-1:0]       fwd_sel_d;
    logic [NUM_SRC*SW-1:0]       sel_comb;
    logic [LAT_WIDTH-1:0]        lat_eff;
    logic                        any_wait;
    logic                        accept;
    logic                        wr_en;
    logic [REGFILE_LEN-1:0]      rs;
    logic [LAT_WIDTH-1:0]        c;
    logic [BW-1:0]               busy_cnt;

    always_comb begin
        lat_eff = issue_lat;
        if (issue_lat == '0) begin
            lat_eff = C_ONE;
        end else if (issue_lat > LAT_MAX) begin
            lat_eff = LAT_MAX;
        end
    end

    // Classification reads pre-update counts, so self-dependence sees the older producer.
    always_comb begin
        any_wait = 1'b0;
        sel_comb = '0;
        rs       = '0;
        c        = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs = src_rs[i*REGFILE_LEN +: REGFILE_LEN];
            c  = ctr_q[rs];
            if (src_valid[i] && (rs != '0)) begin
                unique case (1'b1)
                    (c >= C_THREE): any_wait = 1'b1;
                    (c == C_TWO):   sel_comb[i*SW +: SW] = SEL_EXMEM;
                    (c == C_ONE):   sel_comb[i*SW +: SW] = SEL_MEMWB;
                    default:        sel_comb[i*SW +: SW] = '0;
                endcase
            end
        end
    end

    assign stall  = issue_valid & ~flush & any_wait;
    assign accept = issue_valid & ~stall & ~flush;
    assign wr_en  = accept & issue_reg_write & (issue_rd != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            ctr_d[r] = (ctr_q[r] != '0) ? ctr_q[r] - C_ONE : '0;
        end
        if (wr_en) begin
            ctr_d[issue_rd] = lat_eff + C_ONE;
        end
        ctr_d[0] = '0;
    end

    assign fwd_sel_d = accept ? sel_comb : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                ctr_q[r] <= '0;
            end
            fwd_sel_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                ctr_q[r] <= ctr_d[r];
            end
            fwd_sel_q <= fwd_sel_d;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_cnt = busy_cnt + BW'(ctr_q[r] != '0);
        end
    end

    assign forward_sel = fwd_sel_q;
    assign busy_count  = busy_cnt;

`ifdef FORWARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    assign stall_cycles_d = (stall && (stall_cycles_q != '1))
                          ? stall_cycles_q + 32'd1 : stall_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed testbench for forwarding_scoreboard.
// Define FORWARD_SCOREBOARD_STATS_EN to also check stall_cycles.
module tb_forwarding_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_reg_write;
    logic [5:0]  issue_rd;
    logic [2:0]  issue_lat;
    logic        flush;
    logic [1:0]  src_valid;
    logic [11:0] src_rs;
    logic        stall;
    logic [3:0]  forward_sel;
    logic [6:0]  busy_count;
`ifdef FORWARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    forwarding_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_rd        (issue_rd),
        .issue_lat       (issue_lat),
        .flush           (flush),
        .src_valid       (src_valid),
        .src_rs          (src_rs),
        .stall           (stall),
        .forward_sel     (forward_sel),
        .busy_count      (busy_count)
`ifdef FORWARD_SCOREBOARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic rw, input logic [5:0] rd,
                         input logic [2:0] lat, input logic fl,
                         input logic [1:0] sv, input logic [5:0] rs1,
                         input logic [5:0] rs0);
        issue_valid     = v;
        issue_reg_write = rw;
        issue_rd        = rd;
        issue_lat       = lat;
        flush           = fl;
        src_valid       = sv;
        src_rs          = {rs1, rs0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        repeat (2) tick();
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
        checks++;
        if (forward_sel !== 4'b0000) begin
            failures++; $display("FAIL reset_fwd got=%b exp=0000", forward_sel);
        end
        checks++;
        if (busy_count !== 7'd0) begin
            failures++; $display("FAIL reset_busy got=%0d exp=0", busy_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_x0();
        drive(1, 1, 6'd0, 3'd1, 0, 2'b00, 0, 0);
        tick();
        checks++;
        if (busy_count !== 7'd0) begin
            failures++; $display("FAIL x0_busy got=%0d exp=0", busy_count);
        end
        drive(1, 0, 0, 3'd1, 0, 2'b11, 6'd0, 6'd0);
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL x0_stall got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0000) begin
            failures++; $display("FAIL x0_fwd got=%b exp=0000", forward_sel);
        end
        idle(2);
    endtask

    task automatic test_alu_fwd();
        drive(1, 1, 6'd5, 3'd1, 0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 0, 3'd1, 0, 2'b01, 0, 6'd5);
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL alu_stall got=%b exp=0", stall);
        end
        checks++;
        if (busy_count !== 7'd1) begin
            failures++; $display("FAIL alu_busy got=%0d exp=1", busy_count);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0010) begin
            failures++; $display("FAIL alu_fwd_exmem got=%b exp=0010", forward_sel);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0001) begin
            failures++; $display("FAIL alu_fwd_memwb got=%b exp=0001", forward_sel);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0000) begin
            failures++; $display("FAIL alu_fwd_rf got=%b exp=0000", forward_sel);
        end
        checks++;
        if (busy_count !== 7'd0) begin
            failures++; $display("FAIL alu_busy_end got=%0d exp=0", busy_count);
        end
        idle(2);
    endtask

    task automatic test_load_stall();
        drive(1, 1, 6'd7, 3'd2, 0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 0, 3'd1, 0, 2'b10, 6'd7, 6'd0);
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL load_stall got=%b exp=1", stall);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0000) begin
            failures++; $display("FAIL load_bubble got=%b exp=0000", forward_sel);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL load_release got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b1000) begin
            failures++; $display("FAIL load_fwd got=%b exp=1000", forward_sel);
        end
        idle(6);
    endtask

    task automatic test_waw();
        drive(1, 1, 6'd9, 3'd4, 0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 6'd9, 3'd1, 0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 0, 3'd1, 0, 2'b01, 0, 6'd9);
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL waw_stall got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0010) begin
            failures++; $display("FAIL waw_fwd got=%b exp=0010", forward_sel);
        end
        idle(6);
    endtask

    task automatic test_lat_clamp();
        int n;
        drive(1, 1, 6'd10, 3'd7, 0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 0, 3'd1, 0, 2'b01, 0, 6'd10);
        n = 0;
        while (stall === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        checks++;
        if (n != 3) begin
            failures++; $display("FAIL clamp_hi_stalls got=%0d exp=3", n);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0010) begin
            failures++; $display("FAIL clamp_hi_fwd got=%b exp=0010", forward_sel);
        end
        idle(6);
        drive(1, 1, 6'd11, 3'd0, 0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 0, 3'd1, 0, 2'b10, 6'd11, 0);
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL clamp_lo_stall got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b1000) begin
            failures++; $display("FAIL clamp_lo_fwd got=%b exp=1000", forward_sel);
        end
        idle(6);
    endtask

    task automatic test_flush();
        drive(1, 1, 6'd12, 3'd3, 0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 6'd13, 3'd1, 1, 2'b01, 0, 6'd12);
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL flush_stall got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (forward_sel !== 4'b0000) begin
            failures++; $display("FAIL flush_fwd got=%b exp=0000", forward_sel);
        end
        checks++;
        if (busy_count !== 7'd1) begin
            failures++; $display("FAIL flush_busy got=%0d exp=1", busy_count);
        end
        idle(6);
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 6'd20, 3'd2, 0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 6'd1, 3'd4, 0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 6'd2, 3'd4, 0, 2'b01, 0, 6'd20);
        tick();
        checks++;
        if (busy_count !== 7'd3) begin
            failures++; $display("FAIL mid_busy got=%0d exp=3", busy_count);
        end
        checks++;
        if (forward_sel !== 4'b0010) begin
            failures++; $display("FAIL mid_fwd got=%b exp=0010", forward_sel);
        end
`ifdef FORWARD_SCOREBOARD_STATS_EN
        checks++;
        if (stall_cycles !== 32'd4) begin
            failures++; $display("FAIL stats_total got=%0d exp=4", stall_cycles);
        end
`endif
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_count !== 7'd0) begin
            failures++; $display("FAIL rst_busy got=%0d exp=0", busy_count);
        end
        checks++;
        if (forward_sel !== 4'b0000) begin
            failures++; $display("FAIL rst_fwd got=%b exp=0000", forward_sel);
        end
`ifdef FORWARD_SCOREBOARD_STATS_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++; $display("FAIL rst_stats got=%0d exp=0", stall_cycles);
        end
`endif
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_x0();
        test_alu_fwd();
        test_load_stall();
        test_waw();
        test_lat_clamp();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
